// File: rtl/axi_rd_pkg.sv
// Shared types and constants for the AXI4 line-read initiator.
package axi_rd_pkg;

    typedef enum logic [1:0] {IDLE, AR_SEND, R_WAIT, RESP} state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam int LINE_OFS = 4;

endpackage

// File: rtl/axi_rd_discard_ctr.sv
// Saturating up/down count of R beats still owed by abandoned or timed-out reads.
module axi_rd_discard_ctr #(
    parameter int DISC_W = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic is_zero,
    output logic is_max
);

    logic [DISC_W-1:0] count;

    assign is_zero = (count == '0);
    assign is_max  = (count == '1);

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (inc && !dec && !is_max)
            count <= count + 1'b1;
        else if (dec && !inc && !is_zero)
            count <= count - 1'b1;
    end

endmodule

// File: rtl/axi_read_initiator.sv
// One-outstanding AXI4 line fetch: REQ -> AR -> single R beat -> RSP, with
// timeout and a stale-beat drain so late beats never reach a newer request.
module axi_read_initiator
    import axi_rd_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 128,
    parameter int TIMEOUT = 256,
    parameter int DISC_W  = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    input  logic              FLUSH,
    output logic [ADDR_W-1:0] ARADDR,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RVALID,
    output logic              RREADY,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [DATA_W-1:0] RSP_DATA,
    output logic              RSP_ERR
);

    localparam int OFS   = $clog2(DATA_W / 8);
    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            state;
    logic [TMR_W-1:0]  timer;
    logic              abort;
    logic              disc_zero, disc_max, disc_inc, disc_dec;
    logic              beat, own_beat, tmo_hit, ar_hs;
    logic              unused_bits;

    // EXOKAY is plain success here; sub-line offset is dropped from ARADDR.
    assign unused_bits = ^{RRESP[0], REQ_ADDR[OFS-1:0]};

    assign REQ_READY = (state == IDLE) & ~FLUSH & ~disc_max & ~RST;
    assign RREADY    = ((state == R_WAIT) | ~disc_zero) & ~RST;
    assign beat      = RVALID & RREADY;
    assign own_beat  = beat & disc_zero & (state == R_WAIT);
    assign ar_hs     = ARVALID & ARREADY;
    assign tmo_hit   = (TIMEOUT != 0) && (state == R_WAIT) && (timer == TMR_LAST) && !own_beat;
    assign disc_dec  = beat & ~disc_zero;

    // Each abandoned read still owes exactly one beat to the drain counter.
    always_comb begin
        disc_inc = 1'b0;
        case (state)
            AR_SEND: disc_inc = ar_hs & (abort | FLUSH);
            R_WAIT:  disc_inc = (FLUSH | tmo_hit) & ~own_beat;
            default: disc_inc = 1'b0;
        endcase
    end

    axi_rd_discard_ctr #(.DISC_W(DISC_W)) u_disc (
        .clk     (CLK),
        .rst     (RST),
        .inc     (disc_inc),
        .dec     (disc_dec),
        .is_zero (disc_zero),
        .is_max  (disc_max)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            ARVALID   <= 1'b0;
            ARADDR    <= '0;
            RSP_VALID <= 1'b0;
            RSP_DATA  <= '0;
            RSP_ERR   <= 1'b0;
            timer     <= '0;
            abort     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (REQ_VALID && REQ_READY) begin
                        ARADDR  <= {REQ_ADDR[ADDR_W-1:OFS], {OFS{1'b0}}};
                        ARVALID <= 1'b1;
                        state   <= AR_SEND;
                    end
                end
                AR_SEND: begin
                    // AR cannot be withdrawn, so a flush only marks the read as abandoned.
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        timer   <= '0;
                        abort   <= 1'b0;
                        state   <= (abort || FLUSH) ? IDLE : R_WAIT;
                    end else if (FLUSH) begin
                        abort <= 1'b1;
                    end
                end
                R_WAIT: begin
                    timer <= timer + 1'b1;
                    if (FLUSH) begin
                        state <= IDLE;
                    end else if (own_beat) begin
                        RSP_DATA  <= RDATA;
                        RSP_ERR   <= RRESP[1];
                        RSP_VALID <= 1'b1;
                        state     <= RESP;
                    end else if (tmo_hit) begin
                        RSP_DATA  <= '0;
                        RSP_ERR   <= 1'b1;
                        RSP_VALID <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (RSP_READY || FLUSH) begin
                        RSP_VALID <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_read_initiator.sv
// Bench for axi_read_initiator: table-driven fetches plus hand sequences for
// timeout, stale-beat drain, flush, saturation and reset.
module tb_axi_read_initiator;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 128;
    localparam int TIMEOUT = 8;
    localparam int DISC_W  = 3;

    logic              CLK, RST;
    logic              REQ_VALID, REQ_READY, FLUSH;
    logic [ADDR_W-1:0] REQ_ADDR, ARADDR;
    logic              ARVALID, ARREADY;
    logic [DATA_W-1:0] RDATA, RSP_DATA;
    logic [1:0]        RRESP;
    logic              RVALID, RREADY, RSP_VALID, RSP_READY, RSP_ERR;

    axi_read_initiator #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .DISC_W(DISC_W)
    ) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ADDR(REQ_ADDR), .FLUSH(FLUSH),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR)
    );

    typedef struct {
        logic [31:0]  addr;
        logic [31:0]  araddr;
        int           ar_stall;
        int           r_delay;
        logic [127:0] rdata;
        logic [1:0]   rresp;
        int           rsp_stall;
        logic         err;
    } vec_t;

    typedef struct {
        logic [127:0] data;
        logic         err;
    } rsp_t;

    vec_t tbl[5];
    rsp_t sb[$];
    int   vec_cnt = 0;
    int   miss_cnt = 0;
    int   ar_hs_cnt = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard side: every response handshake must match the oldest expectation.
    always @(negedge CLK) begin
        if (!RST) begin
            if (ARVALID && ARREADY) ar_hs_cnt++;
            if (RSP_VALID && RSP_READY) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", RSP_VALID, 1'b0);
                end else begin
                    rsp_t e;
                    e = sb.pop_front();
                    chk("rsp_data", RSP_DATA, e.data);
                    chk("rsp_err", RSP_ERR, e.err);
                end
            end
        end
    end

    task automatic fetch(input vec_t v);
        int hs0;
        hs0 = ar_hs_cnt;
        RSP_READY = (v.rsp_stall == 0);
        REQ_VALID = 1'b1;
        REQ_ADDR  = v.addr;
        @(negedge CLK);
        chk("req_ready", REQ_READY, 1'b1);
        tick();
        REQ_VALID = 1'b0;
        for (int i = 0; i < v.ar_stall; i++) begin
            @(negedge CLK);
            chk("ar_hold_valid", ARVALID, 1'b1);
            chk("ar_hold_addr", ARADDR, v.araddr);
            tick();
        end
        ARREADY = 1'b1;
        @(negedge CLK);
        chk("arvalid", ARVALID, 1'b1);
        chk("araddr", ARADDR, v.araddr);
        tick();
        ARREADY = 1'b0;
        repeat (v.r_delay) tick();
        RVALID = 1'b1;
        RDATA  = v.rdata;
        RRESP  = v.rresp;
        sb.push_back('{v.rdata, v.err});
        tick();
        RVALID = 1'b0;
        @(negedge CLK);
        chk("rsp_latency", RSP_VALID, 1'b1);
        for (int i = 0; i < v.rsp_stall; i++) begin
            if (i > 0) @(negedge CLK);
            chk("rsp_hold_valid", RSP_VALID, 1'b1);
            chk("rsp_hold_data", RSP_DATA, v.rdata);
            chk("rsp_hold_req_blocked", REQ_READY, 1'b0);
            tick();
        end
        RSP_READY = 1'b1;
        tick();
        @(negedge CLK);
        chk("one_ar_handshake", ar_hs_cnt - hs0, 1);
        tick();
    endtask

    // Request plus immediate AR handshake; returns one cycle into R_WAIT.
    task automatic issue(input logic [31:0] a);
        REQ_VALID = 1'b1;
        REQ_ADDR  = a;
        @(negedge CLK);
        chk("issue_req_ready", REQ_READY, 1'b1);
        tick();
        REQ_VALID = 1'b0;
        ARREADY   = 1'b1;
        @(negedge CLK);
        chk("issue_araddr", ARADDR, {a[31:4], 4'h0});
        tick();
        ARREADY = 1'b0;
    endtask

    initial begin
        tbl[0] = '{32'h0000_1238, 32'h0000_1230, 0, 0, 128'h00112233445566778899AABBCCDDEEFF, 2'b00, 0, 1'b0};
        tbl[1] = '{32'hDEAD_BEEF, 32'hDEAD_BEE0, 5, 0, 128'h0F0E0D0C0B0A09080706050403020100, 2'b00, 0, 1'b0};
        tbl[2] = '{32'h0000_4004, 32'h0000_4000, 0, 1, 128'hCAFEBABE_00000000_12345678_9ABCDEF0, 2'b10, 3, 1'b1};
        tbl[3] = '{32'h0000_50F0, 32'h0000_50F0, 1, 0, 128'h11111111_22222222_33333333_44444444, 2'b01, 0, 1'b0};
        tbl[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFF0, 0, 3, 128'hFEDCBA98_76543210_FEDCBA98_76543210, 2'b11, 1, 1'b1};

        RST = 1'b1; REQ_VALID = 1'b0; REQ_ADDR = '0; FLUSH = 1'b0; ARREADY = 1'b0;
        RDATA = '0; RRESP = 2'b00; RVALID = 1'b0; RSP_READY = 1'b1;
        repeat (2) tick();
        @(negedge CLK);
        chk("rst_arvalid", ARVALID, 1'b0);
        chk("rst_araddr", ARADDR, 32'h0);
        chk("rst_rsp_valid", RSP_VALID, 1'b0);
        chk("rst_rsp_data", RSP_DATA, 128'h0);
        chk("rst_rsp_err", RSP_ERR, 1'b0);
        chk("rst_req_ready", REQ_READY, 1'b0);
        chk("rst_rready", RREADY, 1'b0);
        tick();
        RST = 1'b0;
        @(negedge CLK);
        chk("idle_req_ready", REQ_READY, 1'b1);
        chk("idle_rready", RREADY, 1'b0);
        tick();

        for (int i = 0; i < 5; i++) fetch(tbl[i]);

        // FLUSH beats a simultaneous request in IDLE.
        REQ_VALID = 1'b1; REQ_ADDR = 32'h0000_0700; FLUSH = 1'b1;
        @(negedge CLK);
        chk("flush_req_ready", REQ_READY, 1'b0);
        tick();
        REQ_VALID = 1'b0; FLUSH = 1'b0;
        @(negedge CLK);
        chk("flush_req_no_ar", ARVALID, 1'b0);
        tick();

        // Timeout with no beat, then the late beat precedes the next request's beat.
        issue(32'h0000_0100);
        sb.push_back('{128'h0, 1'b1});
        repeat (7) tick();
        @(negedge CLK);
        chk("tmo_not_early", RSP_VALID, 1'b0);
        tick();
        @(negedge CLK);
        chk("tmo_valid", RSP_VALID, 1'b1);
        chk("tmo_err", RSP_ERR, 1'b1);
        chk("tmo_data", RSP_DATA, 128'h0);
        tick();
        @(negedge CLK);
        chk("tmo_disc_one", RREADY, 1'b1);
        tick();
        issue(32'h0000_0208);
        RVALID = 1'b1; RRESP = 2'b00; RDATA = {4{32'hAAAA_AAAA}};
        tick();
        RDATA = {4{32'h5555_5555}};
        sb.push_back('{{4{32'h5555_5555}}, 1'b0});
        @(negedge CLK);
        chk("stale_dropped", RSP_VALID, 1'b0);
        tick();
        RVALID = 1'b0;
        @(negedge CLK);
        chk("late_rsp_valid", RSP_VALID, 1'b1);
        tick();
        @(negedge CLK);
        chk("late_disc_zero", RREADY, 1'b0);
        tick();

        // FLUSH while AR is backpressured: AR still completes, beat is owed.
        REQ_VALID = 1'b1; REQ_ADDR = 32'h0000_0300;
        tick();
        REQ_VALID = 1'b0; FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        @(negedge CLK);
        chk("flush_ar_hold", ARVALID, 1'b1);
        tick();
        ARREADY = 1'b1;
        tick();
        ARREADY = 1'b0;
        @(negedge CLK);
        chk("flush_ar_done", ARVALID, 1'b0);
        chk("flush_ar_disc", RREADY, 1'b1);
        chk("flush_ar_no_rsp", RSP_VALID, 1'b0);
        tick();
        RVALID = 1'b1; RDATA = {4{32'hDEAD_DEAD}};
        tick();
        RVALID = 1'b0;
        @(negedge CLK);
        chk("flush_ar_drained", RREADY, 1'b0);
        chk("flush_ar_drop", RSP_VALID, 1'b0);
        tick();

        // FLUSH in R_WAIT together with the own beat: beat consumed, nothing owed.
        issue(32'h0000_0400);
        FLUSH = 1'b1; RVALID = 1'b1; RDATA = {4{32'h1234_5678}};
        tick();
        FLUSH = 1'b0; RVALID = 1'b0;
        @(negedge CLK);
        chk("flush_r_disc", RREADY, 1'b0);
        chk("flush_r_no_rsp", RSP_VALID, 1'b0);
        chk("flush_r_idle", REQ_READY, 1'b1);
        tick();

        // Seven timeouts fill the 3-bit drain counter and block requests.
        for (int i = 0; i < 7; i++) begin
            issue(32'h0000_1000 + i * 16);
            sb.push_back('{128'h0, 1'b1});
            repeat (9) tick();
        end
        REQ_VALID = 1'b1; REQ_ADDR = 32'h0000_2000;
        @(negedge CLK);
        chk("sat_block", REQ_READY, 1'b0);
        tick();
        @(negedge CLK);
        chk("sat_no_ar", ARVALID, 1'b0);
        chk("sat_rready", RREADY, 1'b1);
        tick();
        RVALID = 1'b1; RDATA = '0;
        tick();
        RVALID = 1'b0;
        @(negedge CLK);
        chk("sat_release", REQ_READY, 1'b1);
        tick();
        REQ_VALID = 1'b0; ARREADY = 1'b1;
        tick();
        ARREADY = 1'b0;

        // Reset in R_WAIT with beats still owed.
        RST = 1'b1;
        tick();
        @(negedge CLK);
        chk("rst2_arvalid", ARVALID, 1'b0);
        chk("rst2_araddr", ARADDR, 32'h0);
        chk("rst2_rsp_valid", RSP_VALID, 1'b0);
        chk("rst2_rsp_data", RSP_DATA, 128'h0);
        chk("rst2_rsp_err", RSP_ERR, 1'b0);
        chk("rst2_req_ready", REQ_READY, 1'b0);
        chk("rst2_rready", RREADY, 1'b0);
        tick();
        RST = 1'b0;
        @(negedge CLK);
        chk("rst2_disc_clear", RREADY, 1'b0);
        chk("rst2_req_ready_after", REQ_READY, 1'b1);
        tick();

        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        chk("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000");
        $fatal(1, "watchdog");
    end

endmodule
